btn_step_ctrl: RTL and testbench

- Upstream companion of the PWM duty-cycle stage.
- Turns two raw, bouncy push-button inputs (up/down) into clean single-cycle inc/dec step pulses that drive the PWM's inc/dec inputs directly.
- Functions: 2-flop synchronisation, per-button debounce, hold-to-auto-repeat, and conflict lockout when both buttons are pressed.

---
 rtl/btn_step_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_btn_step_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: turns two bouncy push-buttons into clean inc/dec step pulses for the PWM stage.
// Latency: a step pulse appears DEBOUNCE_CYCLES+1 edges after the first edge that samples a press.
// Backpressure: none; pulses are fire-and-forget. en=0 suppresses all pulses (debounce keeps running).
//
// Ports:
//   clk, rst_              clock (posedge) and synchronous active-low reset
//   en                     step-generation enable
//   btn_up_raw, btn_dn_raw asynchronous raw buttons, active-high
//   inc, dec               registered one-cycle step pulses
//   up_level, dn_level     registered debounced button levels
//   lockout                high while the controller sits in the both-pressed conflict state
module btn_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic clk,
  input  logic rst_,
  input  logic en,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  output logic inc,
  output logic dec,
  output logic up_level,
  output logic dn_level,
  output logic lockout
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD_UP  = 3'd1,
    HOLD_DN  = 3'd2,
    LOCK     = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  // Synchroniser: bit 1 is the value the debounce logic acts on.
  logic [1:0]    up_sync;
  logic [1:0]    dn_sync;
  logic [DW-1:0] up_cnt;
  logic [DW-1:0] dn_cnt;
  logic [DW-1:0] up_cnt_nxt;
  logic [DW-1:0] dn_cnt_nxt;
  logic          up_mis;
  logic          dn_mis;
  logic          up_flip;
  logic          dn_flip;
  logic          up_nxt;
  logic          dn_nxt;
  logic          up_rise;
  logic          dn_rise;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_cnt_nxt;
  logic          rep_first;
  logic          rep_first_nxt;
  logic          inc_nxt;
  logic          dec_nxt;

  // Debounce: the level flips once the synced input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    up_mis     = up_sync[1] ^ up_level;
    dn_mis     = dn_sync[1] ^ dn_level;
    up_flip    = up_mis && (up_cnt == DB_LAST);
    dn_flip    = dn_mis && (dn_cnt == DB_LAST);
    up_nxt     = up_level ^ up_flip;
    dn_nxt     = dn_level ^ dn_flip;
    up_rise    = up_flip && !up_level;
    dn_rise    = dn_flip && !dn_level;
    up_cnt_nxt = (!up_mis || up_flip) ? '0 : up_cnt + 1'b1;
    dn_cnt_nxt = (!dn_mis || dn_flip) ? '0 : dn_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      up_sync  <= '0;
      dn_sync  <= '0;
      up_cnt   <= '0;
      dn_cnt   <= '0;
      up_level <= 1'b0;
      dn_level <= 1'b0;
    end else begin
      up_sync  <= {up_sync[0], btn_up_raw};
      dn_sync  <= {dn_sync[0], btn_dn_raw};
      up_cnt   <= up_cnt_nxt;
      dn_cnt   <= dn_cnt_nxt;
      up_level <= up_nxt;
      dn_level <= dn_nxt;
    end
  end

  // Step FSM. Decisions use the next debounced levels so the first pulse is
  // registered on the same edge the level rises. rep_cnt counts edges since
  // the last pulse; rep_first selects the initial delay vs. the repeat rate.
  always_comb begin
    state_nxt     = state;
    rep_cnt_nxt   = rep_cnt;
    rep_first_nxt = rep_first;
    inc_nxt       = 1'b0;
    dec_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (up_rise && dn_rise) begin
          state_nxt = LOCK;
        end else if (up_rise) begin
          if (en) begin
            state_nxt     = HOLD_UP;
            inc_nxt       = 1'b1;
            rep_cnt_nxt   = '0;
            rep_first_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_REL;
          end
        end else if (dn_rise) begin
          if (en) begin
            state_nxt     = HOLD_DN;
            dec_nxt       = 1'b1;
            rep_cnt_nxt   = '0;
            rep_first_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_REL;
          end
        end
      end
      HOLD_UP: begin
        // A press of the other button wins even if this one releases on the same edge.
        if (dn_rise) begin
          state_nxt = LOCK;
        end else if (!up_nxt) begin
          state_nxt = IDLE;
        end else if (!en) begin
          state_nxt = WAIT_REL;
        end else if (rep_cnt == (rep_first ? DLY_LAST : RATE_LAST)) begin
          inc_nxt       = 1'b1;
          rep_cnt_nxt   = '0;
          rep_first_nxt = 1'b0;
        end else begin
          rep_cnt_nxt = rep_cnt + 1'b1;
        end
      end
      HOLD_DN: begin
        if (up_rise) begin
          state_nxt = LOCK;
        end else if (!dn_nxt) begin
          state_nxt = IDLE;
        end else if (!en) begin
          state_nxt = WAIT_REL;
        end else if (rep_cnt == (rep_first ? DLY_LAST : RATE_LAST)) begin
          dec_nxt       = 1'b1;
          rep_cnt_nxt   = '0;
          rep_first_nxt = 1'b0;
        end else begin
          rep_cnt_nxt = rep_cnt + 1'b1;
        end
      end
      LOCK, WAIT_REL: begin
        // Leave only once both buttons are released, so a held button must be re-pressed.
        if (!up_nxt && !dn_nxt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state     <= IDLE;
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rep_cnt   <= rep_cnt_nxt;
      rep_first <= rep_first_nxt;
      inc       <= inc_nxt;
      dec       <= dec_nxt;
      lockout   <= (state_nxt == LOCK);
    end
  end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// tb_btn_step_ctrl: self-checking bench for btn_step_ctrl (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3).
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Vector table, directed multi-cycle sequences, then random stimulus against a behavioural model.
module tb_btn_step_ctrl;

  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_LOCK = 3;
  localparam int M_WAIT = 4;

  logic clk = 1'b0;
  logic rst_;
  logic en;
  logic up_raw;
  logic dn_raw;
  logic inc;
  logic dec;
  logic up_level;
  logic dn_level;
  logic lockout;

  btn_step_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .en        (en),
    .btn_up_raw(up_raw),
    .btn_dn_raw(dn_raw),
    .inc       (inc),
    .dec       (dec),
    .up_level  (up_level),
    .dn_level  (dn_level),
    .lockout   (lockout)
  );

  always #5 clk = ~clk;

  int vec_n = 0;
  int err_n = 0;
  int g_edge = 0;
  int n_inc = 0;
  int n_dec = 0;
  int inc_q[$];

  // Behavioural model: button history windows and a pressed-since edge stamp.
  bit          m_s1[2];
  bit          m_s2[2];
  bit          m_lv[2];
  logic [DC-1:0] win[2];
  int          age[2];
  int          m_mode = M_IDLE;
  int          m_press = 0;
  bit          m_inc;
  bit          m_dec;
  bit          m_lock;

  typedef struct {
    bit         rst_n;
    bit         en;
    bit         up;
    bit         dn;
    logic [4:0] exp;
  } vec_t;

  vec_t tab[32];
  int   tab_n = 0;

  function automatic bit repeat_due(input int d);
    return (d >= RD) && (((d - RD) % RR) == 0);
  endfunction

  task automatic model_edge();
    bit raw[2];
    bit nl[2];
    bit seen;
    bit ru;
    bit rdn;
    int n;
    n = g_edge + 1;
    m_inc = 1'b0;
    m_dec = 1'b0;
    if (!rst_) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lv[b] = 1'b0; win[b] = '0; age[b] = 0;
      end
      m_mode = M_IDLE;
      m_lock = 1'b0;
      return;
    end
    raw[0] = up_raw;
    raw[1] = dn_raw;
    for (int b = 0; b < 2; b++) begin
      seen    = m_s2[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
      win[b]  = {win[b][DC-2:0], seen};
      if (age[b] < DC) age[b]++;
      nl[b] = m_lv[b];
      // Level flips once the last DC post-toggle samples all disagree with it.
      if (age[b] >= DC && win[b] == {DC{~m_lv[b]}}) begin
        nl[b]  = ~m_lv[b];
        age[b] = 0;
      end
    end
    ru  = nl[0] && !m_lv[0];
    rdn = nl[1] && !m_lv[1];
    case (m_mode)
      M_IDLE: begin
        if (ru && rdn) m_mode = M_LOCK;
        else if (ru) begin
          if (en) begin m_inc = 1'b1; m_mode = M_UP; m_press = n; end
          else m_mode = M_WAIT;
        end else if (rdn) begin
          if (en) begin m_dec = 1'b1; m_mode = M_DN; m_press = n; end
          else m_mode = M_WAIT;
        end
      end
      M_UP: begin
        if (rdn) m_mode = M_LOCK;
        else if (!nl[0]) m_mode = M_IDLE;
        else if (!en) m_mode = M_WAIT;
        else if (repeat_due(n - m_press)) m_inc = 1'b1;
      end
      M_DN: begin
        if (ru) m_mode = M_LOCK;
        else if (!nl[1]) m_mode = M_IDLE;
        else if (!en) m_mode = M_WAIT;
        else if (repeat_due(n - m_press)) m_dec = 1'b1;
      end
      default: begin
        if (!nl[0] && !nl[1]) m_mode = M_IDLE;
      end
    endcase
    m_lv[0] = nl[0];
    m_lv[1] = nl[1];
    m_lock  = (m_mode == M_LOCK);
  endtask

  task automatic check(input string nm, input int got, input int exp);
    vec_n++;
    if (got != exp) begin
      err_n++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", nm, g_edge, got, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    g_edge++;
    if (inc) begin n_inc++; inc_q.push_back(g_edge); end
    if (dec) n_dec++;
  endtask

  task automatic tick_m(input string nm);
    tick();
    check(nm, int'({inc, dec, up_level, dn_level, lockout}),
          int'({m_inc, m_dec, m_lv[0], m_lv[1], m_lock}));
  endtask

  task automatic add(input bit r, input bit e, input bit u, input bit d, input logic [4:0] x);
    tab[tab_n] = '{rst_n: r, en: e, up: u, dn: d, exp: x};
    tab_n++;
  endtask

  initial begin
    int p;
    int f;
    int r;
    int rise_e;
    int snap;
    int fall_e;
    int exp_q[$];

    rst_ = 1'b0; en = 1'b1; up_raw = 1'b0; dn_raw = 1'b0;

    // {inc, dec, up_level, dn_level, lockout}
    repeat (3) add(0, 1, 1, 0, 5'b00000);   // reset held with button pressed
    repeat (5) add(1, 1, 1, 0, 5'b00000);   // post-reset edges 0..4
    add(1, 1, 1, 0, 5'b10100);              // edge 5: level + single inc
    add(1, 1, 1, 0, 5'b00100);
    repeat (5) add(1, 1, 0, 0, 5'b00100);   // release: level still high
    repeat (3) add(1, 1, 0, 0, 5'b00000);   // level falls, no pulse
    repeat (5) add(1, 1, 1, 0, 5'b00000);   // clean press, 6 cycles
    add(1, 1, 1, 0, 5'b10100);
    repeat (5) add(1, 1, 0, 0, 5'b00100);
    repeat (3) add(1, 1, 0, 0, 5'b00000);

    for (int i = 0; i < tab_n; i++) begin
      rst_ = tab[i].rst_n; en = tab[i].en; up_raw = tab[i].up; dn_raw = tab[i].dn;
      tick();
      check($sformatf("table[%0d]", i), int'({inc, dec, up_level, dn_level, lockout}), int'(tab[i].exp));
    end

    // Bounce on down: only the final sustained press counts, one dec.
    snap = n_dec;
    rise_e = -1;
    dn_raw = 1'b1; tick_m("bounce");
    dn_raw = 1'b0; tick_m("bounce");
    dn_raw = 1'b1; tick_m("bounce");
    dn_raw = 1'b0; tick_m("bounce");
    dn_raw = 1'b1;
    f = g_edge + 1;
    for (int i = 0; i < 6; i++) begin
      tick_m("bounce");
      if (dn_level && rise_e < 0) rise_e = g_edge;
    end
    dn_raw = 1'b0;
    repeat (8) tick_m("bounce");
    check("bounce_rise_edge", rise_e, f + DC + 1);
    check("bounce_dec_count", n_dec - snap, 1);

    // Auto-repeat: hold up and compare the pulse schedule.
    inc_q.delete();
    up_raw = 1'b1;
    p = g_edge + 1;
    repeat (36) tick_m("repeat");
    up_raw = 1'b0;
    repeat (10) tick_m("repeat");
    fall_e = p + 36 + DC + 1;
    exp_q.push_back(p + DC + 1);
    for (int e = p + DC + 1 + RD; e < fall_e; e += RR) exp_q.push_back(e);
    check("repeat_count", inc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < inc_q.size(); i++)
      check($sformatf("repeat_edge[%0d]", i), inc_q[i], exp_q[i]);

    // Conflict lockout.
    up_raw = 1'b1;
    repeat (16) tick_m("conflict");
    dn_raw = 1'b1;
    repeat (5) tick_m("conflict");
    snap = n_inc + n_dec;
    tick_m("conflict");
    check("lock_set", int'(lockout), 1);
    check("lock_dn_level", int'(dn_level), 1);
    up_raw = 1'b0;
    repeat (8) tick_m("conflict");
    check("lock_hold_one_released", int'(lockout), 1);
    check("lock_up_level_low", int'(up_level), 0);
    dn_raw = 1'b0;
    repeat (8) tick_m("conflict");
    check("lock_cleared", int'(lockout), 0);
    check("lock_no_pulses", n_inc + n_dec - snap, 0);

    // Enable gating mid-repeat, then fresh press.
    up_raw = 1'b1;
    repeat (14) tick_m("gate");
    en = 1'b0;
    snap = n_inc + n_dec;
    repeat (5) tick_m("gate");
    en = 1'b1;
    repeat (12) tick_m("gate");
    check("gate_no_pulses", n_inc + n_dec - snap, 0);
    up_raw = 1'b0;
    repeat (10) tick_m("gate");
    inc_q.delete();
    up_raw = 1'b1;
    r = g_edge + 1;
    repeat (8) tick_m("gate");
    up_raw = 1'b0;
    repeat (10) tick_m("gate");
    check("gate_repress_count", inc_q.size(), 1);
    if (inc_q.size() > 0) check("gate_repress_edge", inc_q[0], r + DC + 1);

    // Random stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      rst_ = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 11) == 0) up_raw = ~up_raw;
      if ($urandom_range(0, 19) == 0) dn_raw = ~dn_raw;
      tick_m("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
